// File: rtl/median_stream_filter.sv
// median_stream_filter
// Streaming sliding-window median filter. The last WIN samples are kept in a
// circular history plus a sorted copy. Each accepted sample updates the sorted
// copy in two steps: evict the oldest sample, then insert the new one.
// Result modes: 00 median, 01 residual (sample - median), 10 bypass, 11 range.
// Build option: define MEDIAN_RESID_SAT_EN to make the residual mode clamp
// negative results to zero instead of wrapping modulo 2^DATA_W.
module median_stream_filter #(
  parameter int DATA_W = 8,
  parameter int WIN    = 8,
  parameter int CNT_W  = $clog2(WIN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        mode,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  fill
);

  localparam int                PTR_W    = $clog2(WIN);
  localparam logic [CNT_W-1:0]  WIN_C    = CNT_W'(WIN);
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(WIN - 1);

  typedef enum logic [1:0] {
    IDLE,
    EVICT,
    INSERT,
    HOLD
  } state_t;

  state_t state;
  state_t state_nxt;

  // Circular history (arrival order) and its sorted copy (ascending).
  logic [DATA_W-1:0] history  [WIN];
  logic [DATA_W-1:0] sorted   [WIN];
  logic [DATA_W-1:0] evicted  [WIN];
  logic [DATA_W-1:0] inserted [WIN];

  logic [PTR_W-1:0]  wr_ptr;
  logic [DATA_W-1:0] sample_q;
  logic [1:0]        mode_q;

  // Number of sorted entries that survive into the insert step.
  logic [CNT_W-1:0]  base_cnt;
  int                ev_pos;
  int                ins_pos;
  logic [PTR_W-1:0]  med_idx;
  logic [PTR_W-1:0]  top_idx;
  logic [DATA_W-1:0] median;
  logic [DATA_W-1:0] resid;
  logic [DATA_W-1:0] result;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values and the update order inside the block is irrelevant.
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake outputs.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no branch can
    // leave it unassigned and infer a latch.
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = EVICT;
      end
      EVICT:  state_nxt = INSERT;
      INSERT: state_nxt = HOLD;
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Eviction: drop the lowest-index sorted entry equal to the oldest sample.
  always_comb begin
    ev_pos = WIN;
    for (int j = WIN - 1; j >= 0; j--) begin
      if (sorted[j] == history[wr_ptr]) ev_pos = j;
    end
    evicted = sorted;
    for (int j = 0; j < WIN - 1; j++) begin
      if (j >= ev_pos) evicted[j] = sorted[j+1];
    end
    if (ev_pos < WIN) evicted[WIN-1] = '0;
  end

  // Stable insertion: the new sample lands after any entries equal to it.
  always_comb begin
    base_cnt = (fill == WIN_C) ? WIN_C - CNT_W'(1) : fill;
    ins_pos  = 0;
    for (int j = 0; j < WIN; j++) begin
      if ((j < int'(base_cnt)) && (sorted[j] <= sample_q)) ins_pos = ins_pos + 1;
    end
    inserted = sorted;
    if (ins_pos == 0) inserted[0] = sample_q;
    for (int j = 1; j < WIN; j++) begin
      if (j == ins_pos) begin
        inserted[j] = sample_q;
      end else if ((j > ins_pos) && (j <= int'(base_cnt))) begin
        inserted[j] = sorted[j-1];
      end
    end
  end

  // Result selection from the post-insert sorted window (lower median on even fill).
  always_comb begin
    med_idx = PTR_W'(base_cnt >> 1);
    top_idx = PTR_W'(base_cnt);
    median  = inserted[med_idx];
    resid   = sample_q - median;
`ifdef MEDIAN_RESID_SAT_EN
    if (sample_q < median) resid = '0;
`endif
    unique case (mode_q)
      2'b00:   result = median;
      2'b01:   result = resid;
      2'b10:   result = sample_q;
      default: result = inserted[top_idx] - inserted[0];
    endcase
  end

  // Window storage, sample latch and registered result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the window arrays are cleared explicitly because a fresh window
      // must read back as all zeros; this forces them into flops, not RAM.
      history  <= '{default: '0};
      sorted   <= '{default: '0};
      fill     <= '0;
      wr_ptr   <= '0;
      sample_q <= '0;
      mode_q   <= '0;
      out_data <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (flush) begin
            fill   <= '0;
            sorted <= '{default: '0};
            wr_ptr <= '0;
          end
          if (in_valid) begin
            sample_q <= in_data;
            mode_q   <= mode;
          end
        end
        EVICT: begin
          if (fill == WIN_C) sorted <= evicted;
        end
        INSERT: begin
          history[wr_ptr] <= sample_q;
          wr_ptr          <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
          sorted          <= inserted;
          fill            <= base_cnt + CNT_W'(1);
          out_data        <= result;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_median_stream_filter.sv
// tb_median_stream_filter
// Two filters (WIN=8 and WIN=3) share one input/output handshake stream, since
// the handshake timing does not depend on WIN. A per-cycle compare process
// checks both against a queue-and-sort reference model; directed phases pin
// the model with hand-computed literal results. Honours MEDIAN_RESID_SAT_EN.
`timescale 1ns/1ps
module tb_median_stream_filter;

  typedef logic [7:0] smp_q_t [$];

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] in_data = '0;
  logic [1:0] mode = '0;
  logic       fixed_ready = 1'b1;
  logic       rnd_ready = 1'b0;
  logic       use_rnd = 1'b0;
  logic       out_ready;

  logic       in_ready8, out_valid8, in_ready3, out_valid3;
  logic [7:0] out_data8, out_data3;
  logic [3:0] fill8;
  logic [1:0] fill3;

  assign out_ready = use_rnd ? rnd_ready : fixed_ready;

`ifdef MEDIAN_RESID_SAT_EN
  logic [7:0] resid_lit = 8'h00;
`else
  logic [7:0] resid_lit = 8'hFE;
`endif

  median_stream_filter #(.DATA_W(8), .WIN(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready8), .in_data(in_data),
    .mode(mode), .flush(flush),
    .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8),
    .fill(fill8)
  );

  median_stream_filter #(.DATA_W(8), .WIN(3)) dut3 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready3), .in_data(in_data),
    .mode(mode), .flush(flush),
    .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3),
    .fill(fill3)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #2;
    rnd_ready = 1'($urandom_range(0, 1));
  end

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference result: sort the whole window from scratch and apply the mode rule.
  function automatic logic [7:0] expect_out(input smp_q_t w, input logic [1:0] m, input logic [7:0] s);
    smp_q_t     srt;
    logic [7:0] tmp;
    logic [7:0] med;
    srt = w;
    for (int i = 0; i < srt.size(); i++) begin
      for (int j = 0; j + 1 < srt.size() - i; j++) begin
        if (srt[j] > srt[j+1]) begin
          tmp = srt[j]; srt[j] = srt[j+1]; srt[j+1] = tmp;
        end
      end
    end
    med = srt[(srt.size() - 1) / 2];
    case (m)
      2'b00: return med;
`ifdef MEDIAN_RESID_SAT_EN
      2'b01: return (s < med) ? 8'd0 : 8'(s - med);
`else
      2'b01: return 8'(s - med);
`endif
      2'b10: return s;
      default: return 8'(srt[srt.size() - 1] - srt[0]);
    endcase
  endfunction

  // Model state and captured results.
  bit         pending = 1'b0;
  bit         exp_valid;
  int         cyc = 0;
  int         valid_from = 0;
  logic [7:0] exp8, exp3;
  int         expf8, expf3;
  smp_q_t     win8, win3;
  logic [7:0] got8 [$];
  logic [7:0] got3 [$];
  int         gotf8 [$];

  // Compare process: checks both DUTs every cycle, then advances the model.
  initial begin
    forever begin
      @(negedge clk);
      cyc = cyc + 1;
      exp_valid = pending && (cyc >= valid_from);
      check("handshake", 32'({in_ready8, in_ready3, out_valid8, out_valid3}),
            32'({!pending, !pending, exp_valid, exp_valid}));
      if (exp_valid) begin
        check("data_w8", 32'(out_data8), 32'(exp8));
        check("data_w3", 32'(out_data3), 32'(exp3));
        check("fill_w8", 32'(fill8), expf8);
        check("fill_w3", 32'(fill3), expf3);
      end else if (!pending) begin
        check("idle_fill_w8", 32'(fill8), win8.size());
        check("idle_fill_w3", 32'(fill3), win3.size());
      end

      if (!rst) begin
        pending = 1'b0;
        win8.delete();
        win3.delete();
      end else if (!pending) begin
        if (flush) begin
          win8.delete();
          win3.delete();
        end
        if (in_valid) begin
          win8.push_back(in_data);
          if (win8.size() > 8) void'(win8.pop_front());
          win3.push_back(in_data);
          if (win3.size() > 3) void'(win3.pop_front());
          exp8       = expect_out(win8, mode, in_data);
          exp3       = expect_out(win3, mode, in_data);
          expf8      = win8.size();
          expf3      = win3.size();
          pending    = 1'b1;
          valid_from = cyc + 3;
        end
      end else if (exp_valid && out_ready) begin
        got8.push_back(out_data8);
        got3.push_back(out_data3);
        gotf8.push_back(int'(fill8));
        pending = 1'b0;
      end
    end
  end

  // All drivers run at posedge + 2 and return at posedge + 2.
  task automatic send(input logic [7:0] d, input logic [1:0] m, input logic fl);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    mode     = m;
    flush    = fl;
    do begin
      @(negedge clk);
      n = n + 1;
    end while (!in_ready8 && n < 200);
    if (!in_ready8) check("accept_timeout", 32'(in_ready8), 1);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic do_flush();
    int n = 0;
    flush = 1'b1;
    do begin
      @(negedge clk);
      n = n + 1;
    end while (!in_ready8 && n < 200);
    if (!in_ready8) check("flush_timeout", 32'(in_ready8), 1);
    @(posedge clk);
    #2;
    flush = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n = n + 1;
    end while (!in_ready8 && n < 200);
    if (!in_ready8) check("idle_timeout", 32'(in_ready8), 1);
    @(posedge clk);
    #2;
  endtask

  initial begin
    int base;
    int n;
    int         p1_out [3]  = '{5, 1, 5};
    int         p1_fill [3] = '{1, 2, 3};
    int         p3_rng [4]  = '{0, 0, 0, 4};
    logic [7:0] d;
    int         r;

    // Reset state.
    repeat (3) @(posedge clk);
    #2;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid8), 0);
    check("rst_out_data", 32'(out_data8), 0);
    check("rst_in_ready", 32'(in_ready8), 1);
    check("rst_fill", 32'(fill8), 0);
    @(posedge clk);
    #2;
    rst = 1'b1;

    // 5,1,9 median stream from an empty window.
    base = got8.size();
    send(8'd5, 2'b00, 1'b0);
    send(8'd1, 2'b00, 1'b0);
    send(8'd9, 2'b00, 1'b0);
    wait_idle();
    check("p1_count", got8.size() - base, 3);
    if (got8.size() >= base + 3) begin
      for (int i = 0; i < 3; i++) begin
        check("p1_median", 32'(got8[base+i]), p1_out[i]);
        check("p1_fill", gotf8[base+i], p1_fill[i]);
      end
    end

    // Full WIN=8 window, then eviction of the oldest (10).
    do_flush();
    for (int v = 10; v <= 80; v += 10) send(8'(v), 2'b00, 1'b0);
    send(8'd5, 2'b00, 1'b0);
    wait_idle();
    check("p2_median_w8", 32'(got8[got8.size()-1]), 40);
    check("p2_fill_w8", gotf8[gotf8.size()-1], 8);
    check("p2_median_w3", 32'(got3[got3.size()-1]), 70);

    // Duplicates in range mode.
    do_flush();
    base = got3.size();
    send(8'd7, 2'b11, 1'b0);
    send(8'd7, 2'b11, 1'b0);
    send(8'd7, 2'b11, 1'b0);
    send(8'd3, 2'b11, 1'b0);
    wait_idle();
    if (got3.size() >= base + 4) begin
      for (int i = 0; i < 4; i++) check("p3_range_w3", 32'(got3[base+i]), p3_rng[i]);
    end else begin
      check("p3_count", got3.size() - base, 4);
    end

    // Residual below and above the median (median 5 in both windows).
    do_flush();
    base = got8.size();
    send(8'd5, 2'b00, 1'b0);
    send(8'd5, 2'b00, 1'b0);
    send(8'd3, 2'b01, 1'b0);
    send(8'd9, 2'b01, 1'b0);
    wait_idle();
    check("p4_count", got8.size() - base, 4);
    if (got8.size() >= base + 4) begin
      check("p4_resid_neg_w8", 32'(got8[base+2]), 32'(resid_lit));
      check("p4_resid_neg_w3", 32'(got3[base+2]), 32'(resid_lit));
      check("p4_resid_pos_w8", 32'(got8[base+3]), 4);
      check("p4_resid_pos_w3", 32'(got3[base+3]), 4);
    end

    // Backpressure: result held 6 cycles while the next sample waits.
    fixed_ready = 1'b0;
    base = got8.size();
    send(8'd100, 2'b10, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n = n + 1;
    end while (!out_valid8 && n < 50);
    if (!out_valid8) check("bp_valid_timeout", 32'(out_valid8), 1);
    @(posedge clk);
    #2;
    in_valid = 1'b1;
    in_data  = 8'd200;
    mode     = 2'b10;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("bp_hold_data", 32'(out_data8), 100);
      check("bp_hold_in_ready", 32'(in_ready8), 0);
    end
    @(posedge clk);
    #2;
    fixed_ready = 1'b1;
    send(8'd200, 2'b10, 1'b0);
    wait_idle();
    check("bp_count", got8.size() - base, 2);
    if (got8.size() >= base + 2) begin
      check("bp_first", 32'(got8[base]), 100);
      check("bp_second", 32'(got8[base+1]), 200);
    end

    // Flush while idle, then 42; then flush and accept in the same cycle.
    do_flush();
    send(8'd42, 2'b00, 1'b0);
    wait_idle();
    check("flush_median", 32'(got8[got8.size()-1]), 42);
    check("flush_fill", gotf8[gotf8.size()-1], 1);
    send(8'd9, 2'b00, 1'b0);
    send(8'd17, 2'b11, 1'b1);
    wait_idle();
    check("flush_accept_range", 32'(got8[got8.size()-1]), 0);
    check("flush_accept_fill", gotf8[gotf8.size()-1], 1);

    // Reset asserted while the filter sits in INSERT.
    send(8'd77, 2'b00, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_insert_out_valid", 32'(out_valid8), 0);
    check("rst_insert_fill", 32'(fill8), 0);
    check("rst_insert_in_ready", 32'(in_ready8), 1);
    check("rst_insert_out_data", 32'(out_data8), 0);
    @(posedge clk);
    #2;
    rst = 1'b1;

    // Randomised traffic with random downstream backpressure.
    use_rnd = 1'b1;
    for (int k = 0; k < 250; k++) begin
      r = int'($urandom_range(0, 99));
      if (r < 5) do_flush();
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #2;
      end
      if (r < 50) d = 8'($urandom_range(0, 7));
      else        d = 8'($urandom_range(0, 255));
      send(d, 2'($urandom_range(0, 3)), (r >= 5 && r < 10) ? 1'b1 : 1'b0);
    end
    use_rnd = 1'b0;
    fixed_ready = 1'b1;
    wait_idle();

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
